// File: rtl/chebyshev_expand.sv
// Re-expands narrowed, saturated samples to the full working wordlength,
// tagging rail-valued samples and counting them, behind a 2-entry skid buffer.
module chebyshev_expand #(
  parameter int WL                    = 16,
  parameter int I_BITS                = 6,
  parameter int BOUNDARY_BIT_POSITION = 3,
  parameter int CNT_W                 = 16,
  localparam int O_BITS               = WL - (I_BITS - BOUNDARY_BIT_POSITION)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [O_BITS-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WL-1:0]     m_data,
  output logic              m_clip,
  output logic              m_clip_neg,
  input  logic              clr_count,
  output logic [CNT_W-1:0]  clip_count
);

  localparam logic [O_BITS-1:0] POS_RAIL  = {1'b0, {(O_BITS-1){1'b1}}};
  localparam logic [O_BITS-1:0] NEG_RAIL  = {1'b1, {(O_BITS-1){1'b0}}};
  localparam logic [CNT_W-1:0]  COUNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t          state;
  logic            skid_valid;
  logic [WL-1:0]   skid_data;
  logic            skid_clip;
  logic            skid_clip_neg;

  logic [WL-1:0]   in_data;
  logic            in_clip;
  logic            in_clip_neg;
  logic            in_fire;
  logic            out_fire;

  // Flags are decided once at acceptance and then travel with the word.
  assign in_data     = {{(WL-O_BITS){s_data[O_BITS-1]}}, s_data};
  assign in_clip_neg = (s_data == NEG_RAIL);
  assign in_clip     = (s_data == POS_RAIL) || in_clip_neg;

  assign s_ready  = ~skid_valid;
  assign in_fire  = s_valid & s_ready;
  assign out_fire = m_valid & m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= EMPTY;
      m_valid       <= 1'b0;
      m_data        <= '0;
      m_clip        <= 1'b0;
      m_clip_neg    <= 1'b0;
      skid_valid    <= 1'b0;
      skid_data     <= '0;
      skid_clip     <= 1'b0;
      skid_clip_neg <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            m_data     <= in_data;
            m_clip     <= in_clip;
            m_clip_neg <= in_clip_neg;
            m_valid    <= 1'b1;
            state      <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            m_data     <= in_data;
            m_clip     <= in_clip;
            m_clip_neg <= in_clip_neg;
          end else if (in_fire) begin
            // OUT is stalled, so park the new sample behind it.
            skid_data     <= in_data;
            skid_clip     <= in_clip;
            skid_clip_neg <= in_clip_neg;
            skid_valid    <= 1'b1;
            state         <= FULL;
          end else if (out_fire) begin
            m_valid <= 1'b0;
            state   <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            m_data     <= skid_data;
            m_clip     <= skid_clip;
            m_clip_neg <= skid_clip_neg;
            skid_valid <= 1'b0;
            state      <= ONE;
          end
        end
        default: begin
          m_valid    <= 1'b0;
          skid_valid <= 1'b0;
          state      <= EMPTY;
        end
      endcase
    end
  end

  // Clear takes priority over a same-cycle increment; the count never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clip_count <= '0;
    end else if (clr_count) begin
      clip_count <= '0;
    end else if (out_fire && m_clip && (clip_count != COUNT_MAX)) begin
      clip_count <= clip_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_chebyshev_expand.sv
// Randomized and directed checks of chebyshev_expand against a queue-based
// model of a 2-deep FIFO with sign extension and saturating rail counters.
module tb_chebyshev_expand;

  localparam int WL = 16;
  localparam int O_BITS = 13;
  localparam int POS_VAL = 4095;
  localparam int NEG_VAL = -4096;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid;
  logic [O_BITS-1:0] s_data;
  logic              m_ready;
  logic              clr_count;

  logic              s_ready;
  logic              m_valid;
  logic [WL-1:0]     m_data;
  logic              m_clip;
  logic              m_clip_neg;
  logic [15:0]       clip_count;

  logic              s_ready_b;
  logic              m_valid_b;
  logic [WL-1:0]     m_data_b;
  logic              m_clip_b;
  logic              m_clip_neg_b;
  logic [1:0]        clip_count_b;

  int checks_total = 0;
  int checks_passed = 0;

  int q[$];
  int cnt_a = 0;
  int cnt_b = 0;
  bit accepted = 0;

  always #5 clk = ~clk;

  chebyshev_expand dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_clip(m_clip), .m_clip_neg(m_clip_neg),
    .clr_count(clr_count), .clip_count(clip_count)
  );

  // Narrow-counter instance shares every input with the main one.
  chebyshev_expand #(.CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
    .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b),
    .m_clip(m_clip_b), .m_clip_neg(m_clip_neg_b),
    .clr_count(clr_count), .clip_count(clip_count_b)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks_total++;
    if (observed === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
  endtask

  function automatic int toSigned(input int raw);
    int v;
    v = raw & 32'h1FFF;
    if (v >= 4096) v -= 8192;
    return v;
  endfunction

  function automatic bit isRail(input int raw);
    return (toSigned(raw) == POS_VAL) || (toSigned(raw) == NEG_VAL);
  endfunction

  task automatic checkModel();
    int v;
    checkOutput("m_valid", m_valid, q.size() > 0);
    checkOutput("s_ready", s_ready, q.size() < 2);
    if (q.size() > 0) begin
      v = toSigned(q[0]);
      checkOutput("m_data", m_data, 32'(v) & 32'hFFFF);
      checkOutput("m_clip", m_clip, isRail(q[0]));
      checkOutput("m_clip_neg", m_clip_neg, v == NEG_VAL);
    end
    checkOutput("clip_count", clip_count, cnt_a);
    checkOutput("clip_count_b", clip_count_b, cnt_b);
  endtask

  // One clock: check at the falling edge, then advance the model on the rising edge.
  task automatic cycle();
    bit in_f;
    bit out_f;
    int popped;
    @(negedge clk);
    checkModel();
    in_f  = s_valid && (q.size() < 2);
    out_f = m_ready && (q.size() > 0);
    @(posedge clk);
    accepted = in_f;
    if (out_f) begin
      popped = q.pop_front();
      if (!clr_count && isRail(popped)) begin
        if (cnt_a < 65535) cnt_a++;
        if (cnt_b < 3) cnt_b++;
      end
    end
    if (clr_count) begin
      cnt_a = 0;
      cnt_b = 0;
    end
    if (in_f) q.push_back(int'(s_data));
    #1;
  endtask

  task automatic applyStimulus(input bit v, input int d, input bit r, input bit c);
    s_valid   = v;
    s_data    = O_BITS'(d);
    m_ready   = r;
    clr_count = c;
    cycle();
  endtask

  task automatic offer(input int d, input bit r);
    int n;
    n = 0;
    accepted = 0;
    while (!accepted && n < 50) begin
      applyStimulus(1'b1, d, r, 1'b0);
      n++;
    end
    checkOutput("offer_accepted", accepted, 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      applyStimulus(1'b0, 0, 1'b1, 1'b0);
      n++;
    end
    checkOutput("drain_empty", q.size(), 0);
  endtask

  initial begin
    int sent;
    int cycles;
    int r;
    int d;

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; clr_count = 1'b0;
    #12;
    checkOutput("rst_m_valid", m_valid, 1'b0);
    checkOutput("rst_m_data", m_data, 16'h0000);
    checkOutput("rst_m_clip", m_clip, 1'b0);
    checkOutput("rst_m_clip_neg", m_clip_neg, 1'b0);
    checkOutput("rst_s_ready", s_ready, 1'b1);
    checkOutput("rst_count", clip_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Sign extension and rail boundaries
    applyStimulus(1'b1, 'h0005, 1'b1, 1'b0);
    checkOutput("tp_data_5", m_data, 16'h0005);
    checkOutput("tp_clip_5", m_clip, 1'b0);
    applyStimulus(1'b1, 'h1000, 1'b1, 1'b0);
    checkOutput("tp_data_neg_rail", m_data, 16'hF000);
    checkOutput("tp_clip_neg_rail", {m_clip, m_clip_neg}, 2'b11);
    applyStimulus(1'b1, 'h0FFF, 1'b1, 1'b0);
    checkOutput("tp_data_pos_rail", m_data, 16'h0FFF);
    checkOutput("tp_clip_pos_rail", {m_clip, m_clip_neg}, 2'b10);
    applyStimulus(1'b1, 'h1001, 1'b1, 1'b0);
    checkOutput("tp_data_neg_plus1", m_data, 16'hF001);
    checkOutput("tp_clip_neg_plus1", m_clip, 1'b0);
    applyStimulus(1'b1, 'h0FFE, 1'b1, 1'b0);
    checkOutput("tp_clip_pos_minus1", m_clip, 1'b0);
    checkOutput("tp_count_two", clip_count, 2);
    drain();

    // Backpressure: only two accepted, then ordered release
    applyStimulus(1'b1, 'h0A0A, 1'b0, 1'b0);
    applyStimulus(1'b1, 'h0B0B, 1'b0, 1'b0);
    applyStimulus(1'b1, 'h0C0C, 1'b0, 1'b0);
    applyStimulus(1'b1, 'h0C0C, 1'b0, 1'b0);
    checkOutput("bp_s_ready_low", s_ready, 1'b0);
    checkOutput("bp_head_a", m_data, 16'h0A0A);
    offer('h0C0C, 1'b1);
    offer('h0D0D, 1'b1);
    drain();

    // Narrow counter saturation and clear priority
    applyStimulus(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, (i % 2) ? 'h1000 : 'h0FFF, 1'b1, 1'b0);
    drain();
    checkOutput("sat_count_b", clip_count_b, 2'd3);
    checkOutput("sat_count_a", clip_count, 5);
    applyStimulus(1'b1, 'h1000, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b1);
    checkOutput("clr_wins_b", clip_count_b, 2'd0);
    checkOutput("clr_wins_a", clip_count, 0);

    // Reset while FULL
    applyStimulus(1'b1, 'h0FFF, 1'b0, 1'b0);
    applyStimulus(1'b1, 'h1000, 1'b0, 1'b0);
    checkOutput("full_s_ready", s_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_m_valid", m_valid, 1'b0);
    checkOutput("midrst_s_ready", s_ready, 1'b1);
    q.delete();
    cnt_a = 0;
    cnt_b = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 0, 1'b1, 1'b0);

    // Random traffic with ~30% rails
    sent = 0;
    cycles = 0;
    while (sent < 10000 && cycles < 30000) begin
      r = $urandom_range(0, 99);
      if (r < 15) d = 'h0FFF;
      else if (r < 30) d = 'h1000;
      else d = int'($urandom & 32'h1FFF);
      applyStimulus($urandom_range(0, 99) < 80, d, $urandom_range(0, 99) < 75, 1'b0);
      if (accepted) sent++;
      cycles++;
    end
    checkOutput("rand_sent", sent, 10000);
    drain();
    applyStimulus(1'b0, 0, 1'b1, 1'b0);

    $display("[TB] %0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
